rename_map_unit: RTL

- Rename stage: consumer of the ID/RN pipeline register; sole driver of that register's `stall` input.
- Maps architectural rs1/rs2/rd to physical registers through a speculative register alias table (RAT) and allocates destinations from a circular free list.
- Issues one renamed instruction per cycle to dispatch through a registered output slot.
- Commit side: keeps a committed RAT and a committed free-list head; `flush` restores speculative state from them in one cycle.

---
 rtl/rename_map_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rename_map_unit.sv
// Rename stage: maps rs1/rs2/rd through a speculative RAT and allocates destination tags from a circular free list.
// Latency: one cycle from accept to a registered output slot; commit and flush take effect at the next clock edge.
// Backpressure: stall_out holds ID/RN while the free list is empty for a writing instruction or while the output slot is blocked.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_rd_we/in_pc/in_inst   instruction from the ID/RN register
//   stall_out                hold ID/RN (combinational)
//   out_ready/out_valid      dispatch handshake for the output slot
//   out_pc/out_inst/out_rd_we/out_prs1/out_prs2/out_prd/out_old_prd   renamed instruction
//   commit_valid/commit_rd_we/commit_rd/commit_prd/commit_old_prd     retirement from the ROB
//   flush                    squash speculative state back to the committed state
module rename_map_unit #(
    parameter int NPHYS  = 64,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_rd_we,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    output logic              stall_out,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              out_rd_we,
    output logic [PREG_W-1:0] out_prs1,
    output logic [PREG_W-1:0] out_prs2,
    output logic [PREG_W-1:0] out_prd,
    output logic [PREG_W-1:0] out_old_prd,
    input  logic              commit_valid,
    input  logic              commit_rd_we,
    input  logic [4:0]        commit_rd,
    input  logic [PREG_W-1:0] commit_prd,
    input  logic [PREG_W-1:0] commit_old_prd,
    input  logic              flush
);

    localparam int FL_DEPTH = NPHYS - 32;
    localparam int FL_AW    = $clog2(FL_DEPTH);
    localparam int PTR_W    = FL_AW + 1;

    logic [PREG_W-1:0] spec_rat [32];
    logic [PREG_W-1:0] cmt_rat  [32];
    logic [PREG_W-1:0] fl       [FL_DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  spec_head;
    logic [PTR_W-1:0]  cmt_head;
    logic [PTR_W-1:0]  tail;

    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              fl_empty;
    logic              need_alloc;
    logic              accept;
    logic              alloc;
    logic              commit_fire;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] alloc_tag;
    logic [PREG_W-1:0] old_tag;

    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign rd  = in_inst[11:7];

    always_comb begin
        fl_empty    = (tail == spec_head);
        need_alloc  = in_valid && in_rd_we && (rd != 5'd0);
        // Empty is judged before any same-cycle commit push: a freed tag is
        // only visible to the allocator from the following cycle.
        stall_out   = (need_alloc && fl_empty) || (out_valid && !out_ready);
        accept      = in_valid && !stall_out && !flush;
        alloc       = accept && need_alloc;
        commit_fire = commit_valid && commit_rd_we && (commit_rd != 5'd0);
        prs1        = (rs1 == 5'd0) ? '0 : spec_rat[rs1];
        prs2        = (rs2 == 5'd0) ? '0 : spec_rat[rs2];
        alloc_tag   = fl[spec_head[FL_AW-1:0]];
        old_tag     = spec_rat[rd];
    end

    // Speculative RAT: a flush copies the committed RAT including the
    // commit that retires in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) spec_rat[i] <= PREG_W'(i);
        end else if (flush) begin
            for (int i = 0; i < 32; i++)
                spec_rat[i] <= (commit_fire && commit_rd == 5'(i)) ? commit_prd : cmt_rat[i];
        end else if (alloc) begin
            spec_rat[rd] <= alloc_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cmt_rat[i] <= PREG_W'(i);
        end else if (commit_fire) begin
            cmt_rat[commit_rd] <= commit_prd;
        end
    end

    // Free list storage and tail: commits push the displaced tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PREG_W'(32 + i);
            tail <= PTR_W'(FL_DEPTH);
        end else if (commit_fire) begin
            fl[tail[FL_AW-1:0]] <= commit_old_prd;
            tail                <= tail + 1'b1;
        end
    end

    // Committed head tracks how many allocations have retired; it is the
    // restore point for the speculative head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmt_head  <= '0;
            spec_head <= '0;
        end else begin
            if (commit_fire) cmt_head <= cmt_head + 1'b1;
            if (flush)
                spec_head <= commit_fire ? cmt_head + 1'b1 : cmt_head;
            else if (alloc)
                spec_head <= spec_head + 1'b1;
        end
    end

    // Output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
            out_rd_we   <= 1'b0;
            out_prs1    <= '0;
            out_prs2    <= '0;
            out_prd     <= '0;
            out_old_prd <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_inst    <= in_inst;
            out_rd_we   <= need_alloc;
            out_prs1    <= prs1;
            out_prs2    <= prs2;
            out_prd     <= need_alloc ? alloc_tag : '0;
            out_old_prd <= need_alloc ? old_tag : '0;
        end else if (flush || out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
